// File: rtl/ram_if.sv
// rtl/ram_if.sv - single-port RAM access bus with master/slave views
interface ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  chip_sel;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output chip_sel,
        output write_enable,
        output data_in,
        output address,
        input  data_out
    );

    modport slave (
        input  chip_sel,
        input  write_enable,
        input  data_in,
        input  address,
        output data_out
    );
endinterface

// File: rtl/ram.sv
// rtl/ram.sv - single-port synchronous RAM, registered write-through read port
// Optional macro RAM_RESET_CLEAR_EN: reset also clears every array word.
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic ck,
    input  logic rst,
    ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  wr_en;

    always_comb begin
        wr_en      = bus.chip_sel & bus.write_enable;
        data_out_d = '0;
        if (bus.chip_sel) begin
            if (bus.write_enable) begin
                data_out_d = bus.data_in;
            end else begin
                data_out_d = mem_q[bus.address];
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

`ifdef RAM_RESET_CLEAR_EN
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[bus.address] <= bus.data_in;
        end
    end
`else
    // No reset on the array so it can map onto block or distributed RAM.
    always_ff @(posedge ck) begin
        if (wr_en && !rst) begin
            mem_q[bus.address] <= bus.data_in;
        end
    end
`endif

    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed self-checking bench for ram
module tb_ram;
    logic ck;
    logic rst;
    int   n_assert;
    int   n_fail;

`ifdef RAM_RESET_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic [3:0] addr, input logic [7:0] din);
        bus.chip_sel     = cs;
        bus.write_enable = we;
        bus.address      = addr;
        bus.data_in      = din;
    endtask

    task automatic access(input logic cs, input logic we, input logic [3:0] addr, input logic [7:0] din);
        drive(cs, we, addr, din);
        @(posedge ck);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        #2;
        check("reset_async", bus.data_out, 8'h00);
        #1;
        rst = 1'b0;

        access(1'b0, 1'b0, 4'd0, 8'h00);
        check("idle_after_reset", bus.data_out, 8'h00);

`ifdef RAM_RESET_CLEAR_EN
        for (int a = 0; a < 16; a++) begin
            access(1'b1, 1'b0, a[3:0], 8'h00);
            check($sformatf("cleared_%0d", a), bus.data_out, 8'h00);
        end
`endif

        access(1'b1, 1'b1, 4'd0, 8'hCA);
        check("write_through_0", bus.data_out, 8'hCA);
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("read_0", bus.data_out, 8'hCA);

        // Input changes between edges must not reach data_out.
        drive(1'b0, 1'b1, 4'd9, 8'hFF);
        #3;
        check("no_comb_path", bus.data_out, 8'hCA);

`ifdef RAM_RESET_CLEAR_EN
        access(1'b1, 1'b0, 4'd7, 8'h00);
        check("read_unwritten_7", bus.data_out, 8'h00);
`endif
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("reread_0", bus.data_out, 8'hCA);

        access(1'b1, 1'b1, 4'd7, 8'hCA);
        check("write_through_7", bus.data_out, 8'hCA);
`ifdef RAM_RESET_CLEAR_EN
        access(1'b1, 1'b0, 4'd8, 8'h00);
        check("read_unwritten_8", bus.data_out, 8'h00);
`endif
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("isolation_0", bus.data_out, 8'hCA);
        access(1'b1, 1'b0, 4'd7, 8'h00);
        check("isolation_7", bus.data_out, 8'hCA);

        access(1'b1, 1'b1, 4'd9, 8'hA5);
        check("write_through_9", bus.data_out, 8'hA5);
        access(1'b1, 1'b0, 4'd7, 8'h00);
        check("b2b_read_7", bus.data_out, 8'hCA);
        access(1'b1, 1'b0, 4'd9, 8'h00);
        check("b2b_read_9", bus.data_out, 8'hA5);

        access(1'b0, 1'b1, 4'd0, 8'h55);
        check("cs_low_zero", bus.data_out, 8'h00);
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("cs_low_no_write", bus.data_out, 8'hCA);

        access(1'b1, 1'b1, 4'd3, 8'h3C);
        check("write_through_3", bus.data_out, 8'h3C);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_op", bus.data_out, 8'h00);
        #1;
        rst = 1'b0;
        access(1'b1, 1'b0, 4'd3, 8'h00);
        check("read_3_after_reset", bus.data_out, CLR ? 8'h00 : 8'h3C);
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("read_0_after_reset", bus.data_out, CLR ? 8'h00 : 8'hCA);

        // A write pending while rst is held across the edge is dropped.
        drive(1'b1, 1'b1, 4'd3, 8'h99);
        #1;
        rst = 1'b1;
        @(posedge ck);
        #1;
        check("reset_held_override", bus.data_out, 8'h00);
        rst = 1'b0;
        access(1'b1, 1'b0, 4'd3, 8'h00);
        check("pending_write_lost", bus.data_out, CLR ? 8'h00 : 8'h3C);

        access(1'b1, 1'b1, 4'd15, 8'h81);
        check("write_through_15", bus.data_out, 8'h81);
        access(1'b1, 1'b0, 4'd15, 8'h00);
        check("read_15", bus.data_out, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ram.md
# ram

Single-port synchronous static RAM, 16 words × 8 bits by default, used as the storage array of the FIFO block. One registered read/write port is gated by a chip select. Writes commit on the rising clock edge. Reads return data one clock after the address is sampled.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address width in bits; DEPTH = 2**ADDR_WIDTH words (16 by default).

Ports:
- ck  input  1  clock; all synchronous activity happens on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- chip_sel  input  1  port enable; 0 means no read and no write.
- write_enable  input  1  1 = write cycle, 0 = read cycle; honoured only when chip_sel=1.
- data_in  input  DATA_WIDTH  write data.
- address  input  ADDR_WIDTH  word address, 0..DEPTH-1; every encoding is valid, so there is no out-of-range case.
- data_out  output  DATA_WIDTH  registered read data.

## Operation
- Storage is an array mem[0..DEPTH-1] of DATA_WIDTH-bit words.
- At each rising edge of ck with rst=0, the port acts on the sampled inputs:
  - chip_sel=1, write_enable=1: mem[address] <= data_in; data_out <= data_in (write-through).
  - chip_sel=1, write_enable=0: data_out <= mem[address]; memory unchanged.
  - chip_sel=0: memory unchanged; data_out <= 0.
- Inputs that change between edges have no effect. Only values present at the rising edge matter.
- Reset, on rst asserting and without waiting for a clock edge:
  - data_out = 0.
  - Memory contents follow the Configuration section.
  - rst held high overrides all other inputs.
- Reset in the middle of a write: if rst rises before a clock edge, that pending write is lost. A write already committed at an earlier edge is lost only when RAM_RESET_CLEAR_EN is defined.

## Timing
- Write latency: the data is in the array after the rising edge; a read of the same address at the next edge returns it.
- Read latency: 1 cycle. Address sampled at edge N, data_out valid after edge N, held until edge N+1.
- data_out changes only on a rising edge or on rst assertion. It has no combinational path from any input.
- Back-to-back writes and reads to any addresses are allowed on every cycle, with no wait states.
- When chip_sel is deasserted, data_out reads 0 from the first edge at which chip_sel=0 is sampled.
- Reset release: the first edge with rst=0 performs a normal access.

## Configuration
- Macro RAM_RESET_CLEAR_EN.
- Defined: rst asynchronously clears every word of mem to 0 as well as data_out. An implementation using flip-flops for the array is acceptable.
- Not defined: rst clears only data_out. Memory keeps its contents (X after power-up in simulation), which allows the array to be inferred as block/distributed RAM.

## Test plan
All scenarios use a 10 ns clock with rising edges at 5, 15, 25 … ns, and apply rst=1 for the first 3 ns.
- Reset: rst pulse -> data_out=0x00 immediately, before any clock edge. With RAM_RESET_CLEAR_EN defined, reads of addresses 0..15 all return 0x00.
- Write then read:
  - chip_sel=1, write_enable=1, address=0, data_in=0xCA at edge 15 ns -> data_out=0xCA after 15 ns (write-through).
  - write_enable=0 at edge 25 ns -> data_out=0xCA.
- Unwritten address read: address=7, write_enable=0 -> data_out=0x00 (clear-enabled build) one edge later; mem[0] still 0xCA.
- Second write and address isolation:
  - Write 0xCA to address 7.
  - Then read address 8 -> 0x00 (clear-enabled build).
  - Re-read addresses 0 and 7 -> 0xCA each.
- Chip select gating:
  - chip_sel=0 with write_enable=1, data_in=0x55, address=0 -> data_out=0x00, no write.
  - chip_sel=1, read address 0 -> 0xCA.
- Async reset mid-operation: assert rst between edges after writing 0x3C to address 3 -> data_out=0 immediately. A subsequent read returns 0x00 with RAM_RESET_CLEAR_EN defined and 0x3C without it.
